// File: rtl/xor_update_if.sv
// xor_update_if
//   Bundles the request, bank-read and write-pipeline signals of the XOR update
//   issuer.
//   slave  : issuer side. Takes requests and read data. Drives ready, read
//            address, write-pipeline outputs and status.
//   master : requester/bank side (the mirror image of slave).
interface xor_update_if #(
    parameter int NUM_MUL     = 4,
    parameter int INDEX_WIDTH = 12,
    parameter int DATA_WIDTH  = 64
);
    logic                            req_valid;
    logic                            req_ready;
    logic [INDEX_WIDTH-1:0]          req_index;
    logic [NUM_MUL-1:0]              req_mask;
    logic [NUM_MUL*DATA_WIDTH-1:0]   req_xor;
    logic [INDEX_WIDTH-1:0]          rd_index;
    logic [NUM_MUL*DATA_WIDTH-1:0]   rd_out_update;
    logic                            write_reg_0_valid;
    logic [INDEX_WIDTH-1:0]          write_reg_0_index;
    logic [NUM_MUL-1:0]              arbiter_result;
    logic [NUM_MUL*DATA_WIDTH-1:0]   write_reg_11_xor;
    logic                            busy;
    logic [31:0]                     stall_count;

    modport slave (
        input  req_valid, req_index, req_mask, req_xor, rd_out_update,
        output req_ready, rd_index, write_reg_0_valid, write_reg_0_index,
               arbiter_result, write_reg_11_xor, busy, stall_count
    );

    modport master (
        output req_valid, req_index, req_mask, req_xor, rd_out_update,
        input  req_ready, rd_index, write_reg_0_valid, write_reg_0_index,
               arbiter_result, write_reg_11_xor, busy, stall_count
    );
endinterface

// File: rtl/xor_update_issuer.sv
// xor_update_issuer
//   Read-modify-write initiator for a NUM_MUL-bank update block. An accepted
//   request reads its index from the banks and XORs the returned words with
//   the request operand. It then drives the write pipeline with the cycle
//   offsets the bank side expects. The bank side has no forwarding, so a
//   request stalls while an overlapping update to the same index is in flight.
//   Ports:
//     clk, reset  : single clock; synchronous active-high reset
//     bus (slave) : request handshake (req_*), bank read (rd_index,
//                   rd_out_update), write pipeline (write_reg_0_*,
//                   arbiter_result, write_reg_11_xor), busy and stall_count
module xor_update_issuer #(
    parameter int NUM_MUL     = 4,
    parameter int INDEX_WIDTH = 12,
    parameter int DATA_WIDTH  = 64,
    parameter int RD_LAT      = 2
) (
    input  logic        clk,
    input  logic        reset,
    xor_update_if.slave bus
);
    // The hazard window covers the accept cycle plus RD_LAT+2 registered slots,
    // RD_LAT+3 cycles in total, ending when the bank commits the entry.
    // Slot s holds the request that was accepted s+1 cycles ago.
    localparam int DEPTH = RD_LAT + 2;
    localparam int CAP   = RD_LAT - 1;   // slot present when read data returns
    localparam int LW    = NUM_MUL * DATA_WIDTH;

    logic [DEPTH-1:0]       vld_q, vld_d;
    logic [INDEX_WIDTH-1:0] idx_q [DEPTH];
    logic [INDEX_WIDTH-1:0] idx_d [DEPTH];
    logic [NUM_MUL-1:0]     msk_q [DEPTH];
    logic [NUM_MUL-1:0]     msk_d [DEPTH];
    // The operand is needed only until the read data returns.
    logic [LW-1:0]          xor_q [RD_LAT];
    logic [LW-1:0]          xor_d [RD_LAT];
    logic [INDEX_WIDTH-1:0] last_idx_q, last_idx_d;
    logic [NUM_MUL-1:0]     arb_q, arb_d;
    logic [LW-1:0]          wr11_q, wr11_d;
    logic [31:0]            stall_q, stall_d;
    logic                   hazard;
    logic                   ready;
    logic                   accept;

    // Only lane-overlapping entries count as hazards. An entry with mask 0
    // writes nothing, so it never blocks another request.
    always_comb begin
        hazard = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            if (vld_q[s] && (idx_q[s] == bus.req_index) && |(msk_q[s] & bus.req_mask))
                hazard = 1'b1;
        end
    end

    assign ready  = ~reset & ~hazard;
    assign accept = bus.req_valid & ready;

    assign bus.req_ready        = ready;
    assign bus.rd_index         = accept ? bus.req_index : last_idx_q;
    assign bus.arbiter_result   = arb_q;
    assign bus.write_reg_11_xor = wr11_q;
    assign bus.busy             = |vld_q;
    assign bus.stall_count      = stall_q;

    always_comb begin
        vld_d    = {vld_q[DEPTH-2:0], accept};
        idx_d[0] = bus.req_index;
        msk_d[0] = bus.req_mask;
        for (int s = 1; s < DEPTH; s++) begin
            idx_d[s] = idx_q[s-1];
            msk_d[s] = msk_q[s-1];
        end
        xor_d[0] = bus.req_xor;
        for (int s = 1; s < RD_LAT; s++) begin
            xor_d[s] = xor_q[s-1];
        end
        last_idx_d = accept ? bus.req_index : last_idx_q;
        // Every lane is XORed. Only the lanes enabled in arbiter_result are
        // meaningful to the bank.
        arb_d  = vld_q[CAP] ? msk_q[CAP] : '0;
        wr11_d = vld_q[CAP] ? (bus.rd_out_update ^ xor_q[CAP]) : wr11_q;
        stall_d = stall_q;
        if (bus.req_valid && !ready && (stall_q != '1))
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                idx_q[s] <= '0;
                msk_q[s] <= '0;
            end
            for (int s = 0; s < RD_LAT; s++) begin
                xor_q[s] <= '0;
            end
            last_idx_q <= '0;
            arb_q      <= '0;
            wr11_q     <= '0;
            stall_q    <= '0;
        end else begin
            vld_q      <= vld_d;
            idx_q      <= idx_d;
            msk_q      <= msk_d;
            xor_q      <= xor_d;
            last_idx_q <= last_idx_d;
            arb_q      <= arb_d;
            wr11_q     <= wr11_d;
            stall_q    <= stall_d;
        end
    end

    // The write pipeline entry pulse comes RD_LAT-1 cycles after accept. With
    // RD_LAT=1 that is the accept cycle itself, so the pulse cannot be
    // registered and is driven combinationally.
    generate
        if (RD_LAT == 1) begin : g_wr0_comb
            assign bus.write_reg_0_valid = accept;
            assign bus.write_reg_0_index = bus.req_index;
        end else begin : g_wr0_reg
            logic                   src_valid;
            logic [INDEX_WIDTH-1:0] src_index;
            logic                   wr0_valid_q, wr0_valid_d;
            logic [INDEX_WIDTH-1:0] wr0_index_q, wr0_index_d;

            if (RD_LAT == 2) begin : g_src_accept
                assign src_valid = accept;
                assign src_index = bus.req_index;
            end else begin : g_src_pipe
                assign src_valid = vld_q[RD_LAT-3];
                assign src_index = idx_q[RD_LAT-3];
            end

            always_comb begin
                wr0_valid_d = src_valid;
                wr0_index_d = src_valid ? src_index : wr0_index_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr0_valid_q <= 1'b0;
                    wr0_index_q <= '0;
                end else begin
                    wr0_valid_q <= wr0_valid_d;
                    wr0_index_q <= wr0_index_d;
                end
            end

            assign bus.write_reg_0_valid = wr0_valid_q;
            assign bus.write_reg_0_index = wr0_index_q;
        end
    endgenerate
endmodule

// File: tb/tb_xor_update_issuer.sv
module tb_xor_update_issuer;
    localparam int NUM_MUL     = 4;
    localparam int INDEX_WIDTH = 12;
    localparam int DATA_WIDTH  = 64;
    localparam int RD_LAT      = 2;
    localparam int LW          = NUM_MUL * DATA_WIDTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    xor_update_if #(.NUM_MUL(NUM_MUL), .INDEX_WIDTH(INDEX_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    xor_update_issuer #(
        .NUM_MUL(NUM_MUL), .INDEX_WIDTH(INDEX_WIDTH), .DATA_WIDTH(DATA_WIDTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Bank model: RD_LAT-cycle read and a commit one edge after arbiter_result.
    logic [LW-1:0]          mem [16];
    logic [LW-1:0]          rd_pipe [RD_LAT];
    logic [INDEX_WIDTH-1:0] widx_d1, widx_d2, cm_idx;
    logic [NUM_MUL-1:0]     cm_en = '0;
    logic [LW-1:0]          cm_data;
    logic                   tb_clear = 1'b1;

    always @(posedge clk) begin
        rd_pipe[0] <= mem[bus.rd_index[3:0]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        widx_d1 <= bus.write_reg_0_index;
        widx_d2 <= widx_d1;
        cm_idx  <= widx_d2;
        cm_en   <= bus.arbiter_result;
        cm_data <= bus.write_reg_11_xor;
        if (tb_clear) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            for (int l = 0; l < NUM_MUL; l++)
                if (cm_en[l]) mem[cm_idx[3:0]][l*DATA_WIDTH +: DATA_WIDTH] <= cm_data[l*DATA_WIDTH +: DATA_WIDTH];
        end
    end
    assign bus.rd_out_update = rd_pipe[RD_LAT-1];

    typedef struct { int cyc; logic [INDEX_WIDTH-1:0] idx; } wr0_t;
    typedef struct { int cyc; logic [NUM_MUL-1:0] mask; logic [LW-1:0] data; } arb_t;
    wr0_t q0[$];
    arb_t qa[$];
    logic [LW-1:0] ref_mem [16];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int stall_model = 0;
    int wr0_seen = 0;
    int accept_cyc = 0;
    logic accepted_last = 1'b0;

    function automatic logic [LW-1:0] lane_bits(input logic [NUM_MUL-1:0] m);
        logic [LW-1:0] r;
        r = '0;
        for (int l = 0; l < NUM_MUL; l++) if (m[l]) r[l*DATA_WIDTH +: DATA_WIDTH] = '1;
        return r;
    endfunction

    // Samples at the falling edge, checks against the scoreboard, records the
    // accept, then advances to just after the next rising edge.
    task automatic step();
        wr0_t ew;
        arb_t ea;
        logic [LW-1:0] bm;
        @(negedge clk);
        accepted_last = 1'b0;
        if (reset) begin
            q0.delete();
            qa.delete();
            stall_model = 0;
        end else begin
            while (q0.size() > 0 && q0[0].cyc < cyc) begin
                ew = q0.pop_front();
                n_checks++; n_fail++;
                $display("FAIL wr0_missing: no pulse seen, required at cycle %0d idx %0d", ew.cyc, ew.idx);
            end
            while (qa.size() > 0 && qa[0].cyc < cyc) begin
                ea = qa.pop_front();
                n_checks++; n_fail++;
                $display("FAIL arb_missing: no arbiter_result seen, required %h at cycle %0d", ea.mask, ea.cyc);
            end
            if (bus.write_reg_0_valid) begin
                wr0_seen++;
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr0_unexpected: pulse idx %0d at cycle %0d, none required", bus.write_reg_0_index, cyc);
                end else begin
                    ew = q0.pop_front();
                    if (ew.cyc !== cyc || ew.idx !== bus.write_reg_0_index) begin
                        n_fail++;
                        $display("FAIL wr0_pulse: got cycle %0d idx %0d, required cycle %0d idx %0d",
                                 cyc, bus.write_reg_0_index, ew.cyc, ew.idx);
                    end
                end
            end
            if (bus.arbiter_result !== '0) begin
                n_checks++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL arb_unexpected: arbiter_result %h at cycle %0d, required 0", bus.arbiter_result, cyc);
                end else begin
                    ea = qa.pop_front();
                    bm = lane_bits(ea.mask);
                    if (ea.cyc !== cyc || ea.mask !== bus.arbiter_result ||
                        (bus.write_reg_11_xor & bm) !== (ea.data & bm)) begin
                        n_fail++;
                        $display("FAIL arb_data: got cyc %0d mask %h data %h, required cyc %0d mask %h data %h",
                                 cyc, bus.arbiter_result, bus.write_reg_11_xor & bm, ea.cyc, ea.mask, ea.data & bm);
                    end
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                logic [3:0] a;
                accepted_last = 1'b1;
                accept_cyc = cyc;
                n_checks++;
                if (bus.rd_index !== bus.req_index) begin
                    n_fail++;
                    $display("FAIL rd_index: got %0d, required %0d", bus.rd_index, bus.req_index);
                end
                a = bus.req_index[3:0];
                ref_mem[a] = ref_mem[a] ^ (bus.req_xor & lane_bits(bus.req_mask));
                q0.push_back('{cyc + RD_LAT - 1, bus.req_index});
                if (bus.req_mask != '0) qa.push_back('{cyc + RD_LAT + 1, bus.req_mask, ref_mem[a]});
            end
            if (bus.req_valid && !bus.req_ready) stall_model++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int idx, input logic [NUM_MUL-1:0] mask, input logic [LW-1:0] xd, output int acc);
        bus.req_valid = 1'b1;
        bus.req_index = INDEX_WIDTH'(idx);
        bus.req_mask  = mask;
        bus.req_xor   = xd;
        for (int k = 0; k < 40; k++) begin
            step();
            if (accepted_last) break;
        end
        bus.req_valid = 1'b0;
        acc = accept_cyc;
        if (!accepted_last) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: idx %0d never accepted, required acceptance within 40 cycles", idx);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((bus.busy || q0.size() != 0 || qa.size() != 0) && k < 50) begin
            step();
            k++;
        end
        n_checks++;
        if (bus.busy || q0.size() != 0 || qa.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: busy %0b q0 %0d qa %0d, required all idle", bus.busy, q0.size(), qa.size());
        end
        step();
        step();
    endtask

    task automatic compare_mem(input string name);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (mem[i] !== ref_mem[i]) begin
                n_fail++;
                $display("FAIL %s bank[%0d]: got %h, required %h", name, i, mem[i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_index = '0;
        bus.req_mask  = '0;
        bus.req_xor   = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        reset = 1'b1;
        tb_clear = 1'b1;
        step(); step(); step();
        n_checks++;
        if (bus.req_ready !== 1'b0 || bus.rd_index !== '0 || bus.write_reg_0_valid !== 1'b0 ||
            bus.write_reg_0_index !== '0 || bus.arbiter_result !== '0 || bus.write_reg_11_xor !== '0 ||
            bus.busy !== 1'b0 || bus.stall_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: rdy %b rd %0d w0v %b w0i %0d arb %h w11 %h busy %b stall %0d, required all 0",
                     bus.req_ready, bus.rd_index, bus.write_reg_0_valid, bus.write_reg_0_index,
                     bus.arbiter_result, bus.write_reg_11_xor, bus.busy, bus.stall_count);
        end
        reset = 1'b0;
        tb_clear = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b, required 1", bus.req_ready);
        end
    endtask

    task automatic test_single();
        logic [LW-1:0] xd;
        int t;
        for (int l = 0; l < NUM_MUL; l++) xd[l*DATA_WIDTH +: DATA_WIDTH] = 64'hA5 + 64'(l);
        send(5, 4'hF, xd, t);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy: got %b, required 1", bus.busy);
        end
        drain();
        n_checks++;
        if (mem[5] !== {64'hA8, 64'hA7, 64'hA6, 64'hA5}) begin
            n_fail++;
            $display("FAIL single_readback: got %h, required lanes A8 A7 A6 A5", mem[5]);
        end
    endtask

    task automatic test_back_to_back();
        int t0, t, s0;
        s0 = int'(bus.stall_count);
        send(1, 4'hF, {4{64'h1111}}, t0);
        send(2, 4'hF, {4{64'h2222}}, t);
        send(3, 4'hF, {4{64'h3333}}, t);
        send(4, 4'hF, {4{64'h4444}}, t);
        n_checks++;
        if (t - t0 != 3 || int'(bus.stall_count) != s0) begin
            n_fail++;
            $display("FAIL b2b_throughput: span %0d stalls %0d, required span 3 stalls 0", t - t0, int'(bus.stall_count) - s0);
        end
        drain();
        compare_mem("b2b");
    endtask

    task automatic test_hazard();
        int t1, t2, s0;
        logic [LW-1:0] x1, x2;
        x1 = {64'h0123_4567_89AB_CDEF, 64'h1, 64'h2, 64'h3};
        x2 = {64'hFFFF_0000_FFFF_0000, 64'h10, 64'h20, 64'h30};
        s0 = int'(bus.stall_count);
        send(7, 4'hF, x1, t1);
        send(7, 4'hF, x2, t2);
        n_checks++;
        if (t2 - t1 != 5 || int'(bus.stall_count) - s0 != 4) begin
            n_fail++;
            $display("FAIL hazard_stall: accept gap %0d stalls %0d, required gap 5 stalls 4", t2 - t1, int'(bus.stall_count) - s0);
        end
        drain();
        n_checks++;
        if (mem[7] !== (x1 ^ x2)) begin
            n_fail++;
            $display("FAIL hazard_data: got %h, required %h", mem[7], x1 ^ x2);
        end
    endtask

    task automatic test_disjoint();
        int t1, t2;
        send(9, 4'b0001, {4{64'hDEAD_BEEF}}, t1);
        send(9, 4'b0010, {4{64'hCAFE_F00D}}, t2);
        n_checks++;
        if (t2 - t1 != 1) begin
            n_fail++;
            $display("FAIL disjoint_no_stall: accept gap %0d, required 1", t2 - t1);
        end
        drain();
        n_checks++;
        if (mem[9] !== {64'h0, 64'h0, 64'hCAFE_F00D, 64'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL disjoint_data: got %h, required lanes 0 0 CAFEF00D DEADBEEF", mem[9]);
        end
    endtask

    task automatic test_mask0();
        logic [LW-1:0] old;
        int t, w0;
        old = mem[3];
        w0 = wr0_seen;
        send(3, 4'b0000, {4{64'hFFFF_FFFF_FFFF_FFFF}}, t);
        drain();
        n_checks++;
        if (mem[3] !== old || wr0_seen - w0 != 1) begin
            n_fail++;
            $display("FAIL mask0: bank %h pulses %0d, required bank %h pulses 1", mem[3], wr0_seen - w0, old);
        end
    endtask

    task automatic test_reset_mid();
        logic [LW-1:0] old;
        int t;
        old = mem[10];
        send(10, 4'hF, {4{64'h5A5A}}, t);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        ref_mem[10] = old;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.write_reg_0_valid !== 1'b0 || bus.arbiter_result !== '0 || bus.stall_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy %b w0v %b arb %h stall %0d, required 0 0 0 0",
                     bus.busy, bus.write_reg_0_valid, bus.arbiter_result, bus.stall_count);
        end
        drain();
        n_checks++;
        if (mem[10] !== old) begin
            n_fail++;
            $display("FAIL reset_mid_bank: got %h, required %h", mem[10], old);
        end
    endtask

    task automatic test_random();
        int t;
        logic [LW-1:0] xd;
        for (int n = 0; n < 40; n++) begin
            for (int l = 0; l < NUM_MUL; l++) xd[l*DATA_WIDTH +: DATA_WIDTH] = {$urandom, $urandom};
            send(int'($urandom_range(0, 7)), NUM_MUL'($urandom_range(0, 15)), xd, t);
        end
        drain();
        compare_mem("random");
        n_checks++;
        if (int'(bus.stall_count) !== stall_model) begin
            n_fail++;
            $display("FAIL stall_count: got %0d, required %0d", bus.stall_count, stall_model);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hazard();
        test_disjoint();
        test_mask0();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
